rr_arbiter8: RTL

- Round-robin arbiter that shares one resource between 8 requesters.
- Output grant is a one-hot 8-bit vector plus its 3-bit binary index, matching the team's 3-to-8 decoder and 8-to-3 priority-encoder datapath.
- Sits in front of the shared resource: requesters raise req, the holder signals done, and the arbiter rotates priority so no requester starves.

---
 rtl/rr_arbiter8.sv | 88 ++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant and a one-cycle gap between holders.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD consecutive grant cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] id_q, id_d, ptr_q, ptr_d, win;
  logic       any, rel, force_rel;
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter8: illegal MAX_HOLD/CNT_W combination");
  end
  // Scan from the farthest offset down so the offset nearest ptr wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) begin
        win = ptr_q + 3'(i);
        any = 1'b1;
      end
    end
  end
  assign rel = done | ~req[id_q];
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q;
  assign force_rel = (state_q == GRANT) && !rel && (hold_q == CNT_W'(MAX_HOLD));
  assign hold_d    = (state_q == GRANT) ? hold_q + 1'b1 : CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= force_rel;
    end
  end
  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (state_q == GRANT) begin
      if (rel || force_rel) begin
        state_d = GAP;
        gnt_d   = '0;
        ptr_d   = id_q + 3'd1;
      end
    end else begin
      state_d = any ? GRANT : IDLE;
      gnt_d   = any ? 8'b1 << win : '0;
      id_d    = any ? win : id_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end
  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
endmodule
